// File: rtl/scrolling_background_if.sv
// Pixel-stream and control bundle between the video timing/game logic and the
// scrolling background generator.
interface scrolling_background_if #(
  parameter int RGB_WIDTH   = 8,
  parameter int PIXEL_WIDTH = 11
);
  logic [PIXEL_WIDTH-1:0] pixelX;
  logic [PIXEL_WIDTH-1:0] pixelY;
  logic                   startOfFrame;
  logic                   scroll_enable;
  logic                   flash_req;
  logic [RGB_WIDTH-1:0]   background_RGB;
  logic [0:1]             bordersDR;
  logic                   flashing;

  modport master (
    output pixelX, pixelY, startOfFrame, scroll_enable, flash_req,
    input  background_RGB, bordersDR, flashing
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, scroll_enable, flash_req,
    output background_RGB, bordersDR, flashing
  );
endinterface

// File: rtl/scrolling_background.sv
// Playfield background: zone border lines, a vertically scrolling hashed
// starfield and a frame-timed border flash. Registered, 1-cycle pixel latency.
module scrolling_background #(
  parameter int RGB_WIDTH              = 8,
  parameter int PIXEL_WIDTH            = 11,
  parameter int X_FRAME_SIZE           = 639,
  parameter int Y_FRAME_SIZE           = 479,
  parameter int MOVEMENT_ZONE_OFFSET   = 20,
  parameter int STATISTICS_ZONE_OFFSET = 20,
  parameter int PLAYER_ZONE_Y          = 310,
  parameter int SCROLL_DIV             = 2,
  parameter logic [7:0] STAR_MASK      = 8'h3F,
  parameter logic [7:0] STAR_SEED      = 8'hA5,
  parameter int FLASH_FRAMES           = 60,
  parameter int FLASH_PERIOD           = 8,
  parameter logic [RGB_WIDTH-1:0] BACKGROUND_COLOR        = 8'h00,
  parameter logic [RGB_WIDTH-1:0] STAR_COLOR              = 8'hFF,
  parameter logic [RGB_WIDTH-1:0] MOVEMENT_ZONE_END_COLOR = 8'h80,
  parameter logic [RGB_WIDTH-1:0] PLAYER_ZONE_END_COLOR   = 8'h10,
  parameter logic [RGB_WIDTH-1:0] STATISTICS_ZONE_COLOR   = 8'h02,
  parameter logic [RGB_WIDTH-1:0] FLASH_COLOR             = 8'hE0
) (
  input logic                  clk,
  input logic                  resetN,
  scrolling_background_if.slave bus
);

  localparam logic [PIXEL_WIDTH-1:0] VL_X  = PIXEL_WIDTH'(MOVEMENT_ZONE_OFFSET);
  localparam logic [PIXEL_WIDTH-1:0] VR_X  = PIXEL_WIDTH'(X_FRAME_SIZE - MOVEMENT_ZONE_OFFSET);
  localparam logic [PIXEL_WIDTH-1:0] PL_Y  = PIXEL_WIDTH'(PLAYER_ZONE_Y);
  localparam logic [PIXEL_WIDTH-1:0] ST_Y  = PIXEL_WIDTH'(Y_FRAME_SIZE - STATISTICS_ZONE_OFFSET);
  localparam logic [PIXEL_WIDTH-1:0] Y_MAX = PIXEL_WIDTH'(Y_FRAME_SIZE);
  localparam logic [PIXEL_WIDTH:0]   YS_MAX  = (PIXEL_WIDTH+1)'(Y_FRAME_SIZE);
  localparam logic [PIXEL_WIDTH:0]   YS_WRAP = (PIXEL_WIDTH+1)'(Y_FRAME_SIZE + 1);

  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam int FC_W = $clog2(FLASH_FRAMES + 1);
  localparam int PH_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FLASH_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_t;

  flash_state_t           state;
  logic [FC_W-1:0]        frame_cnt;
  logic [PH_W-1:0]        phase_cnt;
  logic [PIXEL_WIDTH-1:0] scroll_offset;
  logic [DIV_W-1:0]       frame_div;

  logic                   vert, pl, st, in_region, star;
  logic [PIXEL_WIDTH:0]   ys_sum, ys;
  logic [7:0]             hash;

  // Offset counts down so that stars appear to move down the screen.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scroll_offset <= '0;
      frame_div     <= '0;
    end else if (bus.startOfFrame && bus.scroll_enable) begin
      if (frame_div == DIV_LAST) begin
        frame_div     <= '0;
        scroll_offset <= (scroll_offset == '0) ? Y_MAX : scroll_offset - PIXEL_WIDTH'(1);
      end else begin
        frame_div <= frame_div + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      frame_cnt <= '0;
      phase_cnt <= '0;
    end else if (bus.flash_req) begin
      state     <= FLASH_ON;
      frame_cnt <= FC_W'(FLASH_FRAMES);
      phase_cnt <= '0;
    end else if (bus.startOfFrame && state != IDLE) begin
      frame_cnt <= frame_cnt - FC_W'(1);
      if (frame_cnt == FC_W'(1)) begin
        state <= IDLE;
      end else if (phase_cnt == PH_LAST) begin
        phase_cnt <= '0;
        state     <= (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
      end else begin
        phase_cnt <= phase_cnt + PH_W'(1);
      end
    end
  end

  assign bus.flashing = (state != IDLE);

  always_comb begin
    vert      = (bus.pixelX == VL_X) || (bus.pixelX == VR_X);
    pl        = (bus.pixelY == PL_Y);
    st        = (bus.pixelY == ST_Y);
    in_region = (bus.pixelX > VL_X) && (bus.pixelX < VR_X) && (bus.pixelY < ST_Y);
    // Both terms are below YS_WRAP, so one conditional subtract is a full modulo.
    ys_sum    = {1'b0, bus.pixelY} + {1'b0, scroll_offset};
    ys        = (ys_sum > YS_MAX) ? ys_sum - YS_WRAP : ys_sum;
    hash      = bus.pixelX[7:0] ^ {ys[6:0], 1'b0} ^ ys[9:2] ^ STAR_SEED;
    star      = in_region && ((hash & STAR_MASK) == 8'h00);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.background_RGB <= BACKGROUND_COLOR;
      bus.bordersDR      <= 2'b00;
    end else begin
      bus.bordersDR <= {vert | st, pl | st};
      if (st)
        bus.background_RGB <= STATISTICS_ZONE_COLOR;
      else if (pl)
        bus.background_RGB <= PLAYER_ZONE_END_COLOR;
      else if (vert)
        bus.background_RGB <= (state == FLASH_ON) ? FLASH_COLOR : MOVEMENT_ZONE_END_COLOR;
      else if (star)
        bus.background_RGB <= STAR_COLOR;
      else
        bus.background_RGB <= BACKGROUND_COLOR;
    end
  end

endmodule

// File: tb/tb_scrolling_background.sv
// Scoreboard bench for scrolling_background: randomized pixels and frame
// controls against an arithmetic reference model of lines, stars and flash.
module tb_scrolling_background;

  localparam int XF = 639, YF = 479, MZO = 20, SZO = 20, PLY = 310;
  localparam int SD = 2, FFR = 6, FPER = 2;
  localparam int ST_Y = YF - SZO, VR_X = XF - MZO;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  scrolling_background_if #(.RGB_WIDTH(8), .PIXEL_WIDTH(11)) bus ();

  scrolling_background #(
    .SCROLL_DIV  (SD),
    .FLASH_FRAMES(FFR),
    .FLASH_PERIOD(FPER)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  typedef struct {int rgb; int bdr; int fl; int x; int y;} exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  bit issued = 1'b0;

  // Reference model state: enabled frame pulses seen, frames since flash trigger.
  int m_sof_cnt = 0;
  int m_f = 0;
  bit m_active = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_offset();
    int steps;
    steps = m_sof_cnt / SD;
    return ((YF + 1) - (steps % (YF + 1))) % (YF + 1);
  endfunction

  function automatic bit is_star(input int x, input int y);
    int ys;
    bit [9:0] y10;
    bit [7:0] h;
    bit [7:0] x8;
    if (!(x > MZO && x < VR_X && y < ST_Y)) return 1'b0;
    ys  = (y + m_offset()) % (YF + 1);
    y10 = ys[9:0];
    x8  = x[7:0];
    h   = x8 ^ {y10[6:0], 1'b0} ^ y10[9:2] ^ 8'hA5;
    return (h & 8'h3F) == 8'h00;
  endfunction

  function automatic int m_rgb(input int x, input int y);
    bit flash_on;
    flash_on = m_active && (((m_f / FPER) % 2) == 0);
    if (y == ST_Y) return 8'h02;
    if (y == PLY) return 8'h10;
    if (x == MZO || x == VR_X) return flash_on ? 8'hE0 : 8'h80;
    if (is_star(x, y)) return 8'hFF;
    return 8'h00;
  endfunction

  function automatic int m_bdr(input int x, input int y);
    bit v, p, s;
    v = (x == MZO) || (x == VR_X);
    p = (y == PLY);
    s = (y == ST_Y);
    return {30'd0, v | s, p | s};
  endfunction

  task automatic m_step(input bit sof, input bit en, input bit freq);
    if (sof && en) m_sof_cnt++;
    if (freq) begin
      m_active = 1'b1;
      m_f = 0;
    end else if (sof && m_active) begin
      m_f++;
      if (m_f >= FFR) m_active = 1'b0;
    end
  endtask

  task automatic cycle(input int x, input int y, input bit sof, input bit en, input bit freq);
    exp_t e;
    @(negedge clk);
    bus.pixelX        = x[10:0];
    bus.pixelY        = y[10:0];
    bus.startOfFrame  = sof;
    bus.scroll_enable = en;
    bus.flash_req     = freq;
    e.rgb = m_rgb(x, y);
    e.bdr = m_bdr(x, y);
    e.x = x;
    e.y = y;
    m_step(sof, en, freq);
    e.fl = int'(m_active);
    q.push_back(e);
    issued = 1'b1;
  endtask

  task automatic rand_pixel(output int x, output int y);
    if ($urandom_range(0, 9) < 7) begin
      x = $urandom_range(MZO, VR_X);
      y = $urandom_range(0, ST_Y);
    end else begin
      x = $urandom_range(0, 2047);
      y = $urandom_range(0, 2047);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.flash_req    = 1'b0;
    #2 resetN = 1'b0;
    #1;
    check("rst_flashing", int'(bus.flashing), 0);
    check("rst_scroll_offset", int'(dut.scroll_offset), 0);
    check("rst_rgb", int'(bus.background_RGB), 8'h00);
    m_sof_cnt = 0;
    m_f = 0;
    m_active = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Monitor: every driven cycle yields one registered output one edge later.
  initial begin
    bit v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = issued;
      issued = 1'b0;
      if (v) begin
        #1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got output with no expectation");
        end else begin
          e = q.pop_front();
          check($sformatf("rgb(%0d,%0d)", e.x, e.y), int'(bus.background_RGB), e.rgb);
          check($sformatf("bdr(%0d,%0d)", e.x, e.y),
                int'({bus.bordersDR[0], bus.bordersDR[1]}), e.bdr);
          check($sformatf("flashing(%0d,%0d)", e.x, e.y), int'(bus.flashing), e.fl);
        end
      end
    end
  end

  initial begin
    int x, y, sx, sy;
    bit found;
    bus.pixelX = 11'd20;
    bus.pixelY = 11'd100;
    bus.startOfFrame = 1'b0;
    bus.scroll_enable = 1'b0;
    bus.flash_req = 1'b0;

    #12;
    check("reset_rgb", int'(bus.background_RGB), 8'h00);
    check("reset_bdr", int'({bus.bordersDR[0], bus.bordersDR[1]}), 0);
    check("reset_flashing", int'(bus.flashing), 0);
    @(negedge clk);
    resetN = 1'b1;

    // Line decode and priority
    cycle(20, 100, 0, 0, 0);
    cycle(20, 459, 0, 0, 0);
    cycle(619, 310, 0, 0, 0);
    cycle(300, 310, 0, 0, 0);
    cycle(619, 459, 0, 0, 0);
    cycle(21, 458, 0, 0, 0);
    cycle(618, 0, 0, 0, 0);
    cycle(1500, 310, 0, 0, 0);
    cycle(20, 2000, 0, 0, 0);

    // Static starfield
    for (int i = 0; i < 1500; i++) begin
      rand_pixel(x, y);
      cycle(x, y, 0, 0, 0);
    end

    // Locate a star to follow across a scroll step
    found = 1'b0;
    sx = 100;
    sy = 100;
    for (int i = 0; i < 20000 && !found; i++) begin
      x = $urandom_range(MZO + 1, VR_X - 1);
      y = $urandom_range(0, ST_Y - 2);
      if (is_star(x, y)) begin
        found = 1'b1;
        sx = x;
        sy = y;
      end
    end
    cycle(sx, sy, 0, 0, 0);

    // Scroll: two steps, then frozen
    for (int i = 0; i < 2; i++) cycle(sx, sy, 1, 1, 0);
    cycle(sx, sy + 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cycle(300, 200, 1, 1, 0);
    @(posedge clk); #1;
    check("scroll_offset_after_4", int'(dut.scroll_offset), 478);
    for (int i = 0; i < 3; i++) cycle(300, 200, 1, 0, 0);
    @(posedge clk); #1;
    check("scroll_offset_frozen", int'(dut.scroll_offset), m_offset());
    for (int i = 0; i < 400; i++) begin
      rand_pixel(x, y);
      cycle(x, y, 0, 0, 0);
    end

    // Flash sequence, one border sample per frame
    cycle(20, 100, 0, 0, 1);
    for (int f = 0; f < FFR + 1; f++) begin
      cycle(20, 100, 0, 0, 0);
      cycle(619, 50, 1, 0, 0);
    end
    cycle(20, 100, 0, 0, 0);

    // Retrigger coinciding with a frame pulse
    cycle(20, 100, 0, 0, 1);
    for (int f = 0; f < 2; f++) begin
      cycle(20, 100, 0, 0, 0);
      cycle(20, 100, 1, 0, 0);
    end
    cycle(20, 100, 1, 1, 1);
    for (int f = 0; f < FFR + 1; f++) begin
      cycle(619, 100, 0, 0, 0);
      cycle(20, 100, 1, 0, 0);
    end

    // Randomized mixed traffic
    for (int i = 0; i < 3000; i++) begin
      rand_pixel(x, y);
      if ($urandom_range(0, 3) == 0) x = ($urandom_range(0, 1) == 0) ? MZO : VR_X;
      cycle(x, y, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 59) == 0);
    end

    // Reset in the middle of a flash with the starfield scrolled
    cycle(20, 100, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(20, 100, 1, 1, 0);
    do_reset();
    for (int i = 0; i < 200; i++) begin
      rand_pixel(x, y);
      cycle(x, y, $urandom_range(0, 5) == 0, 1, 0);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scrolling_background.md
Name: scrolling_background

Overview:
- Parametrised successor to the static playfield background.
- Draws the movement-zone side borders, the player-zone line and the statistics line at parameterised positions.
- Adds a vertically scrolling pseudo-random starfield inside the playfield, and a border-flash mode triggered by game logic (e.g. an enemy reaching the player zone).
- Sits at the bottom of the drawing-priority mux; registered output, 1-cycle latency from pixelX/pixelY.

Parameters:
- RGB_WIDTH, 8, colour width.
- PIXEL_WIDTH, 11, pixel coordinate width.
- X_FRAME_SIZE, 639, last visible X.
- Y_FRAME_SIZE, 479, last visible Y.
- MOVEMENT_ZONE_OFFSET, 20, side border X distance from each frame edge.
- STATISTICS_ZONE_OFFSET, 20, statistics line distance above Y_FRAME_SIZE.
- PLAYER_ZONE_Y, 310, Y of player-zone line.
- SCROLL_DIV, 2, frames per 1-pixel starfield scroll step; must be ≥1.
- STAR_MASK, 8'h3F, low-bit mask of the star hash; a star is drawn where masked hash == 0.
- STAR_SEED, 8'hA5, hash seed.
- FLASH_FRAMES, 60, flash duration in frames.
- FLASH_PERIOD, 8, frames per flash half-period.
- BACKGROUND_COLOR, 8'h00; STAR_COLOR, 8'hFF; MOVEMENT_ZONE_END_COLOR, 8'h80; PLAYER_ZONE_END_COLOR, 8'h10; STATISTICS_ZONE_COLOR, 8'h02; FLASH_COLOR, 8'hE0.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset.
- pixelX  in  PIXEL_WIDTH  current pixel X.
- pixelY  in  PIXEL_WIDTH  current pixel Y.
- startOfFrame  in  1  one-cycle pulse at frame start.
- scroll_enable  in  1  starfield scrolls while high.
- flash_req  in  1  one-cycle pulse that starts or restarts the flash.
- background_RGB  out  RGB_WIDTH  pixel colour.
- bordersDR  out  [0:1]  border drawing requests: bit0 = vertical borders or statistics line; bit1 = player line or statistics line.
- flashing  out  1  high while the flash sequence is active.

Behaviour:
- Clock and reset: one clock, clk. Reset resetN is asynchronous, active-low.
- Reset values: background_RGB=BACKGROUND_COLOR, bordersDR=2'b00, flashing=0, scroll_offset=0, frame_div=0, FSM=IDLE, counters=0.
- Output latency: background_RGB and bordersDR are registered, 1 cycle after pixelX/pixelY. flashing is a direct decode of the registered FSM state.
- Line decode:
  - vert: pixelX==MOVEMENT_ZONE_OFFSET or pixelX==X_FRAME_SIZE-MOVEMENT_ZONE_OFFSET.
  - pl: pixelY==PLAYER_ZONE_Y.
  - st: pixelY==Y_FRAME_SIZE-STATISTICS_ZONE_OFFSET.
- bordersDR:
  - bit0 = vert | st.
  - bit1 = pl | st.
  - Coincident lines OR their bits together.
- Colour priority, highest first:
  - st → STATISTICS_ZONE_COLOR.
  - pl → PLAYER_ZONE_END_COLOR.
  - vert → FLASH_COLOR if FSM==FLASH_ON, else MOVEMENT_ZONE_END_COLOR.
  - star → STAR_COLOR.
  - else → BACKGROUND_COLOR.
- Star region: strictly MOVEMENT_ZONE_OFFSET < pixelX < X_FRAME_SIZE-MOVEMENT_ZONE_OFFSET, and pixelY < statistics line Y.
- Star test:
  - ys = pixelY + scroll_offset; if ys > Y_FRAME_SIZE then ys -= Y_FRAME_SIZE+1 (single conditional subtract).
  - hash = pixelX[7:0] ^ {ys[6:0],1'b0} ^ ys[9:2] ^ STAR_SEED.
  - Star iff (hash & STAR_MASK)==0.
- Scroll:
  - On startOfFrame with scroll_enable=1, frame_div increments.
  - When frame_div reaches SCROLL_DIV-1: frame_div←0, and scroll_offset←scroll_offset==0 ? Y_FRAME_SIZE : scroll_offset-1. Stars therefore move down 1 pixel per step.
  - scroll_enable=0 freezes both frame_div and scroll_offset.
- Flash FSM: IDLE, FLASH_ON, FLASH_OFF.
  - frame_cnt counts remaining frames; phase_cnt counts frames within the current half-period.
  - flash_req in any state → FLASH_ON, frame_cnt←FLASH_FRAMES, phase_cnt←0. Retrigger restarts the sequence.
  - On startOfFrame while not IDLE:
    - frame_cnt decrements.
    - If frame_cnt==1 → IDLE.
    - Otherwise phase_cnt increments; at FLASH_PERIOD-1, phase_cnt←0 and state toggles ON↔OFF.
  - flash_req and startOfFrame in the same cycle: flash_req wins; no decrement.
  - flashing = (state != IDLE).
- Reset mid-operation: asserting resetN low returns all state to reset values immediately; any flash is aborted and the scroll position is lost.
- Out-of-frame coordinates (pixelX > X_FRAME_SIZE or pixelY > Y_FRAME_SIZE): no star, lines only on exact match.

Test Plan:
- Reset: hold resetN=0, drive pixelX=20 → background_RGB=8'h00, bordersDR=00, flashing=0. Release reset, pixelX=20, pixelY=100 → next cycle 8'h80, bordersDR=2'b10... bit0=1, bit1=0.
- Line priority: pixelX=20, pixelY=459 → 8'h02, bordersDR bit0=1 and bit1=1. pixelX=619, pixelY=310 → 8'h10, both bits 1. pixelX=300, pixelY=310 → 8'h10, bit1 only.
- Starfield: scroll_offset=0, scan pixelY=0..458 with pixelX=21..618 → STAR_COLOR exactly where the hash rule matches (scoreboard model). pixelX=20 or pixelY≥459 → never STAR_COLOR.
- Scroll: SCROLL_DIV=2, scroll_enable=1, 4 startOfFrame pulses → scroll_offset 0→479→478. Drop scroll_enable, 3 pulses → offset stays 478. A star seen at (x,y) before a step appears at (x,y+1) after it.
- Flash: FLASH_FRAMES=6, FLASH_PERIOD=2, flash_req pulse, then 6 startOfFrame pulses → border colour sequence ON,ON,OFF,OFF,ON,ON per frame, then flashing=0 and colour 8'h80.
- Retrigger and reset: flash_req in the same cycle as startOfFrame at frame 3 → count restarts at 6 in FLASH_ON. resetN low mid-flash → flashing=0, scroll_offset=0 in the same cycle as the reset assertion.
